mbt_frame_scheduler: RTL and testbench

Frame-level sequencer for the four-lane Mandelbrot ALU datapath. It accepts a frame request carrying the view window (x_min, y_max, zoom_level) and walks the pixel grid in 4-pixel batches. For each batch it clears and starts the ALU quartet, collects the four per-lane valid pulses, and issues one 4-lane BRAM write. It replaces free-running pixel stepping with an explicit request/busy/done handshake, and adds a one-deep pending-request queue and a per-batch timeout.

---
 rtl/mbt_frame_scheduler.sv | 199 +++++++++++++++++++
 tb/tb_mbt_frame_scheduler.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mbt_frame_scheduler.sv
// Frame sequencer for the four-lane Mandelbrot ALU: walks the pixel grid in 4-pixel batches,
// pulses clear/start to the ALU quartet, gathers lane valids and issues one BRAM word write per batch.
module mbt_frame_scheduler #(
  parameter int H_RES    = 320,
  parameter int V_RES    = 240,
  parameter int MAX_WAIT = 1023
) (
  input  logic        clk_fast,
  input  logic        rst,
  input  logic        frame_req,
  input  logic [15:0] x_min_in,
  input  logic [15:0] y_max_in,
  input  logic [1:0]  zoom_in,
  input  logic        abort,
  output logic [15:0] x_min,
  output logic [15:0] y_max,
  output logic [1:0]  zoom_level,
  output logic [15:0] i_x,
  output logic [15:0] i_y,
  output logic        alu_rst,
  output logic        alu_start,
  input  logic [3:0]  alu_valid,
  output logic [3:0]  wea,
  output logic [16:0] addr,
  output logic        busy,
  output logic        frame_done,
  output logic        timeout_err
);

  localparam int CNT_W = (MAX_WAIT > 1) ? $clog2(MAX_WAIT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_WAIT - 1);
  localparam logic [15:0]      X_LAST   = 16'(H_RES - 4);
  localparam logic [15:0]      Y_LAST   = 16'(V_RES - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_START,
    S_WAIT,
    S_WRITE,
    S_DONE
  } state_t;

  state_t           state_q;
  logic [15:0]      x_min_q, y_max_q;
  logic [1:0]       zoom_q;
  logic [15:0]      sh_x_min_q, sh_y_max_q;
  logic [1:0]       sh_zoom_q;
  logic             pend_q;
  logic [15:0]      i_x_q, i_y_q;
  logic [16:0]      addr_q;
  logic [3:0]       mask_q;
  logic [CNT_W-1:0] cnt_q;
  logic             alu_rst_q, alu_start_q, busy_q, frame_done_q, timeout_q;
  logic [3:0]       wea_q;

  logic [15:0] i_x_d, i_y_d;
  logic [16:0] addr_d;
  logic        lanes_done, wait_expired, last_batch;

  // Next batch position: raster order, word address advances in lock-step.
  always_comb begin
    i_x_d  = i_x_q + 16'd4;
    i_y_d  = i_y_q;
    addr_d = addr_q + 17'd1;
    if (i_x_q == X_LAST) begin
      i_x_d = 16'd0;
      i_y_d = i_y_q + 16'd1;
    end
  end

  assign lanes_done   = ((mask_q | alu_valid) == 4'hF);
  assign wait_expired = (cnt_q == CNT_LAST);
  assign last_batch   = (i_x_q == X_LAST) && (i_y_q == Y_LAST);

  always_ff @(posedge clk_fast or negedge rst) begin
    if (!rst) begin
      state_q      <= S_IDLE;
      x_min_q      <= '0;
      y_max_q      <= '0;
      zoom_q       <= '0;
      sh_x_min_q   <= '0;
      sh_y_max_q   <= '0;
      sh_zoom_q    <= '0;
      pend_q       <= 1'b0;
      i_x_q        <= '0;
      i_y_q        <= '0;
      addr_q       <= '0;
      mask_q       <= '0;
      cnt_q        <= '0;
      alu_rst_q    <= 1'b0;
      alu_start_q  <= 1'b0;
      busy_q       <= 1'b0;
      frame_done_q <= 1'b0;
      timeout_q    <= 1'b0;
      wea_q        <= '0;
    end else begin
      alu_rst_q    <= 1'b0;
      alu_start_q  <= 1'b0;
      frame_done_q <= 1'b0;
      wea_q        <= '0;

      // A request arriving mid-frame is parked; the newest one overwrites older ones.
      if (frame_req && (state_q != S_IDLE)) begin
        sh_x_min_q <= x_min_in;
        sh_y_max_q <= y_max_in;
        sh_zoom_q  <= zoom_in;
        pend_q     <= 1'b1;
      end

      if (abort && (state_q != S_IDLE)) begin
        state_q   <= S_IDLE;
        alu_rst_q <= 1'b1;
        busy_q    <= 1'b0;
        pend_q    <= 1'b0;
      end else begin
        case (state_q)
          S_IDLE: begin
            if (frame_req || pend_q) begin
              if (frame_req) begin
                x_min_q <= x_min_in;
                y_max_q <= y_max_in;
                zoom_q  <= zoom_in;
              end else begin
                x_min_q <= sh_x_min_q;
                y_max_q <= sh_y_max_q;
                zoom_q  <= sh_zoom_q;
              end
              i_x_q     <= '0;
              i_y_q     <= '0;
              addr_q    <= '0;
              timeout_q <= 1'b0;
              pend_q    <= 1'b0;
              busy_q    <= 1'b1;
              alu_rst_q <= 1'b1;
              state_q   <= S_CLEAR;
            end
          end
          S_CLEAR: begin
            alu_start_q <= 1'b1;
            state_q     <= S_START;
          end
          S_START: begin
            mask_q  <= '0;
            cnt_q   <= '0;
            state_q <= S_WAIT;
          end
          S_WAIT: begin
            mask_q <= mask_q | alu_valid;
            if (lanes_done) begin
              wea_q   <= 4'hF;
              state_q <= S_WRITE;
            end else if (wait_expired) begin
              timeout_q <= 1'b1;
              wea_q     <= 4'hF;
              state_q   <= S_WRITE;
            end else begin
              cnt_q <= cnt_q + 1'b1;
            end
          end
          S_WRITE: begin
            if (last_batch) begin
              frame_done_q <= 1'b1;
              state_q      <= S_DONE;
            end else begin
              i_x_q     <= i_x_d;
              i_y_q     <= i_y_d;
              addr_q    <= addr_d;
              alu_rst_q <= 1'b1;
              state_q   <= S_CLEAR;
            end
          end
          S_DONE: begin
            busy_q  <= 1'b0;
            state_q <= S_IDLE;
          end
          default: begin
            busy_q  <= 1'b0;
            state_q <= S_IDLE;
          end
        endcase
      end
    end
  end

  assign x_min       = x_min_q;
  assign y_max       = y_max_q;
  assign zoom_level  = zoom_q;
  assign i_x         = i_x_q;
  assign i_y         = i_y_q;
  assign addr        = addr_q;
  assign alu_rst     = alu_rst_q;
  assign alu_start   = alu_start_q;
  assign wea         = wea_q;
  assign busy        = busy_q;
  assign frame_done  = frame_done_q;
  assign timeout_err = timeout_q;

endmodule

// File: tb/tb_mbt_frame_scheduler.sv
// Bench for mbt_frame_scheduler on an 8x2 grid: table-driven frames, pending/abort/timeout/reset
// sequences, and randomized lane latencies against a batch-level timing model.
module tb_mbt_frame_scheduler;

  localparam int H  = 8;
  localparam int V  = 2;
  localparam int NB = (H / 4) * V;

  logic clk_fast = 1'b0;
  always #5 clk_fast = ~clk_fast;

  logic        rst, frame_req, abort;
  logic [15:0] x_min_in, y_max_in;
  logic [1:0]  zoom_in;
  logic [3:0]  alu_valid = '0;
  logic [3:0]  valid_to;

  logic [15:0] x_min, y_max, i_x, i_y;
  logic [1:0]  zoom_level;
  logic        alu_rst, alu_start, busy, frame_done, timeout_err;
  logic [3:0]  wea;
  logic [16:0] addr;

  logic [15:0] to_x_min, to_y_max, to_i_x, to_i_y;
  logic [1:0]  to_zoom;
  logic        to_alu_rst, to_alu_start, to_busy, to_frame_done, to_timeout_err;
  logic [3:0]  to_wea;
  logic [16:0] to_addr;

  mbt_frame_scheduler #(.H_RES(H), .V_RES(V), .MAX_WAIT(16)) dut (
    .clk_fast(clk_fast), .rst(rst), .frame_req(frame_req),
    .x_min_in(x_min_in), .y_max_in(y_max_in), .zoom_in(zoom_in), .abort(abort),
    .x_min(x_min), .y_max(y_max), .zoom_level(zoom_level), .i_x(i_x), .i_y(i_y),
    .alu_rst(alu_rst), .alu_start(alu_start), .alu_valid(alu_valid), .wea(wea),
    .addr(addr), .busy(busy), .frame_done(frame_done), .timeout_err(timeout_err)
  );

  // Second instance with a short wait limit; lane 2 never reports.
  mbt_frame_scheduler #(.H_RES(H), .V_RES(V), .MAX_WAIT(4)) dut_to (
    .clk_fast(clk_fast), .rst(rst), .frame_req(frame_req),
    .x_min_in(x_min_in), .y_max_in(y_max_in), .zoom_in(zoom_in), .abort(abort),
    .x_min(to_x_min), .y_max(to_y_max), .zoom_level(to_zoom), .i_x(to_i_x), .i_y(to_i_y),
    .alu_rst(to_alu_rst), .alu_start(to_alu_start), .alu_valid(valid_to), .wea(to_wea),
    .addr(to_addr), .busy(to_busy), .frame_done(to_frame_done), .timeout_err(to_timeout_err)
  );

  int nvec = 0;
  int nerr = 0;
  int lane_dly [4];
  int rnd_dly [4];
  bit rand_mode = 1'b0;
  int age = -1;
  int cur_maxd = 0;
  int wea_cnt = 0, done_cnt = 0, arst_cnt = 0;

  // ALU quartet model: lane l pulses valid lane_dly[l] cycles after the start cycle (0 = never).
  always @(negedge clk_fast) begin
    if (wea != 4'h0) wea_cnt++;
    if (frame_done) done_cnt++;
    if (alu_rst) arst_cnt++;
    if (alu_start) begin
      age = 0;
      for (int l = 0; l < 4; l++) rnd_dly[l] = $urandom_range(1, 6);
      cur_maxd = 0;
      for (int l = 0; l < 4; l++) begin
        if (rand_mode && rnd_dly[l] > cur_maxd) cur_maxd = rnd_dly[l];
        if (!rand_mode && lane_dly[l] > cur_maxd) cur_maxd = lane_dly[l];
      end
    end else if (age >= 0 && age < 100000) begin
      age++;
    end
    for (int l = 0; l < 4; l++) begin
      if (rand_mode) alu_valid[l] = (age == rnd_dly[l]);
      else alu_valid[l] = (lane_dly[l] != 0) && (age == lane_dly[l]);
    end
  end

  task automatic step();
    @(posedge clk_fast);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", nm, act, exp);
    end
  endtask

  // Entered on the CLEAR cycle of batch 0; returns on the cycle after DONE.
  task automatic frame_body(input logic [15:0] xm, input logic [15:0] ym, input logic [1:0] zm,
                            input int exp_cyc, input int inj_b);
    int w0, d0, n, exp_n;
    w0 = wea_cnt;
    d0 = done_cnt;
    for (int b = 0; b < NB; b++) begin
      chk("clear_pulse", alu_rst, 1);
      chk("busy_clear", busy, 1);
      if (b == inj_b) begin
        frame_req = 1'b1;
        x_min_in  = 16'h1111;
      end
      step();
      n = 2;
      chk("start_pulse", alu_start, 1);
      if (b == inj_b) begin
        x_min_in = 16'h2222;
        y_max_in = 16'h0F0F;
        zoom_in  = 2'd2;
      end
      do begin
        step();
        n++;
        frame_req = 1'b0;
      end while (wea == 4'h0 && n < 200);
      exp_n = (exp_cyc >= 0) ? exp_cyc : cur_maxd + 3;
      chk("batch_cycles", n, exp_n);
      chk("wea", wea, 4'hF);
      chk("addr", addr, b);
      chk("i_x", i_x, 4 * (b % (H / 4)));
      chk("i_y", i_y, b / (H / 4));
      chk("win_x", x_min, xm);
      chk("win_y", y_max, ym);
      chk("win_z", zoom_level, zm);
      step();
    end
    chk("frame_done", frame_done, 1);
    chk("wea_after_last", wea, 0);
    step();
    chk("busy_after_done", busy, 0);
    chk("done_once", frame_done, 0);
    chk("writes_per_frame", wea_cnt - w0, NB);
    chk("dones_per_frame", done_cnt - d0, 1);
  endtask

  task automatic run_frame(input logic [15:0] xm, input logic [15:0] ym, input logic [1:0] zm,
                           input int exp_cyc, input int inj_b);
    x_min_in  = xm;
    y_max_in  = ym;
    zoom_in   = zm;
    frame_req = 1'b1;
    step();
    frame_req = 1'b0;
    frame_body(xm, ym, zm, exp_cyc, inj_b);
  endtask

  typedef struct {
    logic [15:0] xm;
    logic [15:0] ym;
    logic [1:0]  zm;
    int d0, d1, d2, d3;
    int cyc;
  } row_t;

  row_t tbl [4];

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int a0, w0, d0, n;
    tbl[0] = '{xm: 16'hE000, ym: 16'h1000, zm: 2'd1, d0: 2, d1: 2, d2: 2, d3: 2, cyc: 5};
    tbl[1] = '{xm: 16'h0123, ym: 16'h4567, zm: 2'd2, d0: 1, d1: 3, d2: 3, d3: 7, cyc: 10};
    tbl[2] = '{xm: 16'h1234, ym: 16'hABCD, zm: 2'd3, d0: 1, d1: 1, d2: 1, d3: 1, cyc: 4};
    tbl[3] = '{xm: 16'hFFFF, ym: 16'h8000, zm: 2'd0, d0: 5, d1: 4, d2: 3, d3: 2, cyc: 8};

    rst = 1'b0; frame_req = 1'b0; abort = 1'b0;
    x_min_in = '0; y_max_in = '0; zoom_in = '0; valid_to = 4'b1011;
    for (int l = 0; l < 4; l++) lane_dly[l] = 2;
    repeat (2) step();
    chk("rst_x_min", x_min, 0);
    chk("rst_y_max", y_max, 0);
    chk("rst_zoom", zoom_level, 0);
    chk("rst_i_x", i_x, 0);
    chk("rst_i_y", i_y, 0);
    chk("rst_addr", addr, 0);
    chk("rst_wea", wea, 0);
    chk("rst_ctrl", {alu_rst, alu_start, busy, frame_done, timeout_err}, 0);
    chk("rst_to_all", |{to_x_min, to_y_max, to_zoom, to_i_x, to_i_y, to_alu_rst, to_alu_start,
                        to_busy, to_frame_done, to_timeout_err, to_wea, to_addr}, 0);
    rst = 1'b1;
    step();

    for (int r = 0; r < 4; r++) begin
      lane_dly[0] = tbl[r].d0; lane_dly[1] = tbl[r].d1;
      lane_dly[2] = tbl[r].d2; lane_dly[3] = tbl[r].d3;
      run_frame(tbl[r].xm, tbl[r].ym, tbl[r].zm, tbl[r].cyc, -1);
      step();
    end

    // Two busy-time requests: current frame keeps its window, the latest request runs next.
    for (int l = 0; l < 4; l++) lane_dly[l] = 2;
    run_frame(16'hAAAA, 16'h5555, 2'd1, 5, 1);
    chk("pend_idle_gap", busy, 0);
    step();
    chk("pend_start_x", x_min, 16'h2222);
    frame_body(16'h2222, 16'h0F0F, 2'd2, 5, -1);
    step();

    // Abort on the same cycle the lane mask completes.
    x_min_in = 16'h3333; frame_req = 1'b1;
    step();
    frame_req = 1'b0;
    repeat (3) step();
    w0 = wea_cnt; d0 = done_cnt; a0 = arst_cnt;
    abort = 1'b1;
    step();
    abort = 1'b0;
    chk("abort_idle", busy, 0);
    chk("abort_rst_pulse", alu_rst, 1);
    chk("abort_no_wea", wea, 0);
    repeat (4) step();
    chk("abort_writes", wea_cnt - w0, 0);
    chk("abort_dones", done_cnt - d0, 0);
    chk("abort_rst_count", arst_cnt - a0, 1);
    chk("abort_stays_idle", busy, 0);

    // Batch timeout on the MAX_WAIT=4 instance.
    rst = 1'b0;
    step();
    rst = 1'b1;
    step();
    frame_req = 1'b1;
    step();
    frame_req = 1'b0;
    chk("to_clear", to_alu_rst, 1);
    step();
    chk("to_start", to_alu_start, 1);
    n = 2;
    do begin
      step();
      n++;
    end while (to_wea == 4'h0 && n < 50);
    chk("to_batch_cycles", n, 7);
    chk("to_wea", to_wea, 4'hF);
    chk("to_addr", to_addr, 0);
    chk("to_err_set", to_timeout_err, 1);
    step();
    chk("to_err_sticky", to_timeout_err, 1);
    abort = 1'b1;
    step();
    abort = 1'b0;
    chk("to_abort_idle", to_busy, 0);
    chk("to_err_idle", to_timeout_err, 1);
    frame_req = 1'b1;
    step();
    frame_req = 1'b0;
    chk("to_err_clear_on_load", to_timeout_err, 0);
    abort = 1'b1;
    step();
    abort = 1'b0;
    step();

    // Asynchronous reset in the WRITE cycle of batch 1.
    x_min_in = 16'h7777; frame_req = 1'b1;
    step();
    frame_req = 1'b0;
    repeat (9) step();
    chk("pre_rst_wea", wea, 4'hF);
    chk("pre_rst_addr", addr, 1);
    #1 rst = 1'b0;
    #1;
    chk("arst_wea", wea, 0);
    chk("arst_busy", busy, 0);
    chk("arst_addr", addr, 0);
    step();
    rst = 1'b1;
    step();
    run_frame(16'h0F00, 16'h00F0, 2'd3, 5, -1);

    // Random lane latencies checked against the batch timing model.
    rand_mode = 1'b1;
    for (int f = 0; f < 4; f++) begin
      repeat ($urandom_range(0, 3)) step();
      run_frame(16'($urandom), 16'($urandom), 2'($urandom), -1, -1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
